dmem_stage_p: RTL

Parametrised data-memory pipeline stage: a two-deep stage between execute and write-back with a single-clock synchronous data RAM and byte-lane writes. Carries the instruction word and N write-back lanes (register index, valid flag, payload) alongside each memory access. Inserts a bubble on `interlock`. Adds same-cycle store-to-load forwarding, which the previous stage lacked.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_ram.sv | 41 ++++
 rtl/dmem_stage_p.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory pipeline stage.
//   NOP_INST_DEFAULT : bubble instruction word used when a stage is empty or stalled
//   lane_t           : one write-back lane (rt, rt_flag, tdata) at default widths
//   be_width()       : number of byte enables for a given data width
package dmem_pkg;

    localparam logic [63:0] NOP_INST_DEFAULT = 64'hE000_0000_E000_0000;

    localparam int unsigned REG_W_DEFAULT   = 5;
    localparam int unsigned TDATA_W_DEFAULT = 32;

    typedef struct packed {
        logic [REG_W_DEFAULT-1:0]   rt;
        logic                       rt_flag;
        logic [TDATA_W_DEFAULT-1:0] tdata;
    } lane_t;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-clock, byte-enabled, read-first synchronous RAM.
// Ports:
//   clk   : clock, rising edge
//   en    : access enable; when low there is no write, no read and rdata holds
//   we    : per-byte write enables (DATA_W/8)
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : registered read data; a same-index same-cycle read returns the old word
// Contents are never cleared; there is deliberately no reset on the array or rdata.
module dmem_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Non-blocking write plus read of the same array gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (we[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_stage_p.sv
// dmem_stage_p: two-deep data-memory pipeline stage (M1 -> M2) between execute and
// write-back, with a byte-enabled synchronous data RAM.
// Optional feature macro: DMEM_STAGE_FWD_EN builds same-cycle store-to-load forwarding.
// Ports:
//   clk, rstn      : clock (rising edge) and asynchronous active-low reset
//   interlock      : stall; M1 and the RAM freeze, M2 loads a bubble
//   mem_used       : request performs a load
//   inst           : instruction word entering the stage
//   wr_addr/data/be: store word address, data, byte enables (be == 0 means no store)
//   rd_addr        : load word address
//   rt/rt_flag/tdata           : per-lane write-back metadata in
//   inst_out/rt_out/rt_flag_out/tdata_out : metadata to write-back
//   rd_data, rd_valid          : load result aligned with inst_out, and its valid
module dmem_stage_p
    import dmem_pkg::*;
#(
    parameter int unsigned          DATA_W   = 64,
    parameter int unsigned          ADDR_W   = 10,
    parameter int unsigned          INST_W   = 64,
    parameter int unsigned          LANES    = 2,
    parameter int unsigned          REG_W    = 5,
    parameter int unsigned          TDATA_W  = 32,
    parameter logic [INST_W-1:0]    NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       interlock,
    input  logic                       mem_used,
    input  logic [INST_W-1:0]          inst,
    input  logic [31:0]                wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic [31:0]                rd_addr,
    input  logic [LANES*REG_W-1:0]     rt,
    input  logic [LANES-1:0]           rt_flag,
    input  logic [LANES*TDATA_W-1:0]   tdata,
    output logic [INST_W-1:0]          inst_out,
    output logic [LANES*REG_W-1:0]     rt_out,
    output logic [LANES-1:0]           rt_flag_out,
    output logic [LANES*TDATA_W-1:0]   tdata_out,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid
);

    localparam int unsigned BE_W = be_width(DATA_W);

    // Accept whenever not stalled; RAM access additionally suppressed during reset.
    logic acc;
    logic ram_en;
    assign acc    = ~interlock;
    assign ram_en = acc & rstn;

    // Addresses wrap modulo the RAM depth; upper bits are intentionally dropped.
    logic [ADDR_W-1:0] widx;
    logic [ADDR_W-1:0] ridx;
    logic              unused_addr_hi;
    assign widx           = wr_addr[ADDR_W-1:0];
    assign ridx           = rd_addr[ADDR_W-1:0];
    assign unused_addr_hi = ^{wr_addr[31:ADDR_W], rd_addr[31:ADDR_W]};

    logic [DATA_W-1:0] ram_rdata;

    dmem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (wr_be),
        .waddr (widx),
        .wdata (wr_data),
        .raddr (ridx),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------------------
    // M1: request metadata, captured alongside the RAM access
    // ------------------------------------------------------------------------------
    logic [INST_W-1:0]        m1_inst;
    logic [LANES*REG_W-1:0]   m1_rt;
    logic [LANES-1:0]         m1_rt_flag;
    logic [LANES*TDATA_W-1:0] m1_tdata;
    logic                     m1_mem_used;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m1_inst     <= NOP_INST;
            m1_rt       <= '0;
            m1_rt_flag  <= '0;
            m1_tdata    <= '0;
            m1_mem_used <= 1'b0;
        end else if (acc) begin
            m1_inst     <= inst;
            m1_rt       <= rt;
            m1_rt_flag  <= rt_flag;
            m1_tdata    <= tdata;
            m1_mem_used <= mem_used;
        end
    end

    // ------------------------------------------------------------------------------
    // Load result feeding M2 (optionally merged with a colliding same-cycle store)
    // ------------------------------------------------------------------------------
    logic [DATA_W-1:0] load_word;

`ifdef DMEM_STAGE_FWD_EN
    // The RAM is read-first, so a colliding load sees the old word; the store's
    // enabled bytes are registered here and overlaid on the RAM output.
    logic              fwd_hit;
    logic              m1_fwd_hit;
    logic [BE_W-1:0]   m1_fwd_be;
    logic [DATA_W-1:0] m1_fwd_wdata;

    assign fwd_hit = (wr_be != '0) && (widx == ridx);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m1_fwd_hit   <= 1'b0;
            m1_fwd_be    <= '0;
            m1_fwd_wdata <= '0;
        end else if (acc) begin
            m1_fwd_hit   <= fwd_hit;
            m1_fwd_be    <= wr_be;
            m1_fwd_wdata <= wr_data;
        end
    end

    always_comb begin
        load_word = ram_rdata;
        if (m1_fwd_hit) begin
            for (int i = 0; i < BE_W; i++) begin
                if (m1_fwd_be[i]) begin
                    load_word[i*8 +: 8] = m1_fwd_wdata[i*8 +: 8];
                end
            end
        end
    end
`else
    assign load_word = ram_rdata;
`endif

    // ------------------------------------------------------------------------------
    // M2: write-back-facing register; a stalled edge loads a bubble
    // ------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_out    <= NOP_INST;
            rt_out      <= '0;
            rt_flag_out <= '0;
            tdata_out   <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else if (acc) begin
            inst_out    <= m1_inst;
            rt_out      <= m1_rt;
            rt_flag_out <= m1_rt_flag;
            tdata_out   <= m1_tdata;
            rd_data     <= load_word;
            rd_valid    <= m1_mem_used;
        end else begin
            // Bubble: kill the instruction and its side effects, hold the data fields.
            inst_out    <= NOP_INST;
            rt_flag_out <= '0;
            rd_valid    <= 1'b0;
        end
    end

endmodule
